// File: rtl/cat_scan_pkg.sv
// Shared types and constants for the channel-scan grant controller.
package cat_scan_pkg;
  localparam int N_CAT    = 6;
  localparam int IBT_BASE = 2;
  localparam int ERRCNT_W = 4;
  localparam int IDX_W    = 3;
  localparam int WDOG_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } state_e;
endpackage

// File: rtl/cat_rr_pick.sv
// Round-robin pick: first pending channel searching upward from last+1, wrapping.
module cat_rr_pick
  import cat_scan_pkg::*;
(
  input  logic [N_CAT-1:0] pending_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int k = 1; k <= N_CAT; k++) begin
      cand = IDX_W'((int'(last_i) + k) % N_CAT);
      if (!valid_o && pending_i[cand]) begin
        valid_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/cat_scan_ctrl.sv
// Channel-scan grant controller: round-robin grant, ACK completion, watchdog timeout.
// state | meaning: IDLE = scanning for requests, GRANT = channel held, ERR = one-cycle timeout recovery
module cat_scan_ctrl
  import cat_scan_pkg::*;
#(
  parameter int WDOG_MAX = 100
) (
  input  logic                CLK,
  input  logic                ICLR,
  input  logic [N_CAT-1:0]    CAT_N,
  input  logic                WATCH,
  input  logic                ACK,
  output logic [2:0]          IBT,
  output logic                GNT,
  output logic                DONE,
  output logic                TOUT,
  output logic [ERRCNT_W-1:0] ERRCNT
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);
  localparam logic [ERRCNT_W-1:0] ERR_SAT = '1;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  gnt_q, gnt_d;
  logic [2:0]            ibt_q, ibt_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;

  logic [N_CAT-1:0]      pending;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  assign pending = ~CAT_N & {N_CAT{WATCH}};

  cat_rr_pick u_pick (
    .pending_i (pending),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    wdog_d   = wdog_q;
    gnt_d    = gnt_q;
    ibt_d    = ibt_q;
    done_d   = 1'b0;
    tout_d   = 1'b0;
    errcnt_d = errcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          idx_d   = pick_idx;
          gnt_d   = 1'b1;
          ibt_d   = pick_idx + 3'(IBT_BASE);
          wdog_d  = '0;
        end
      end
      ST_GRANT: begin
        // ACK takes priority over a watchdog expiry in the same cycle
        if (ACK) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          last_d  = idx_q;
          gnt_d   = 1'b0;
          ibt_d   = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_ERR;
          tout_d  = 1'b1;
          last_d  = idx_q;
          gnt_d   = 1'b0;
          ibt_d   = '0;
          if (errcnt_q != ERR_SAT) errcnt_d = errcnt_q + 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 1'b0;
        ibt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ICLR) begin
      state_q  <= ST_IDLE;
      last_q   <= IDX_W'(N_CAT - 1);
      idx_q    <= '0;
      wdog_q   <= '0;
      gnt_q    <= 1'b0;
      ibt_q    <= '0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      wdog_q   <= wdog_d;
      gnt_q    <= gnt_d;
      ibt_q    <= ibt_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign GNT    = gnt_q;
  assign IBT    = ibt_q;
  assign DONE   = done_q;
  assign TOUT   = tout_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_cat_scan_ctrl.sv
// Randomized and directed bench for cat_scan_ctrl against a grant-level reference model.
module tb_cat_scan_ctrl;
  localparam int WD = 100;

  logic       CLK = 1'b0;
  logic       ICLR = 1'b1;
  logic [5:0] CAT_N = 6'h3f;
  logic       WATCH = 1'b0;
  logic       ACK = 1'b0;
  logic [2:0] IBT;
  logic       GNT, DONE, TOUT;
  logic [3:0] ERRCNT;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: owner channel (-1 = none), age of grant, recovery flag
  int m_ch, m_age, m_last, m_errcnt;
  bit m_err, m_done, m_tout;

  cat_scan_ctrl #(.WDOG_MAX(WD)) dut (
    .CLK(CLK), .ICLR(ICLR), .CAT_N(CAT_N), .WATCH(WATCH), .ACK(ACK),
    .IBT(IBT), .GNT(GNT), .DONE(DONE), .TOUT(TOUT), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit iclr, input logic [5:0] cn, input bit w, input bit a);
    m_done = 0;
    m_tout = 0;
    if (iclr) begin
      m_ch = -1; m_age = 0; m_last = 5; m_errcnt = 0; m_err = 0;
    end else if (m_err) begin
      m_err = 0;
    end else if (m_ch >= 0) begin
      if (a) begin
        m_done = 1; m_last = m_ch; m_ch = -1;
      end else if (m_age == WD - 1) begin
        m_tout = 1; m_err = 1; m_last = m_ch; m_ch = -1;
        if (m_errcnt < 15) m_errcnt++;
      end else begin
        m_age++;
      end
    end else if (w) begin
      for (int k = 1; k <= 6; k++) begin
        int c;
        c = (m_last + k) % 6;
        if (cn[c] == 1'b0) begin
          m_ch = c; m_age = 0;
          break;
        end
      end
    end
  endtask

  task automatic step(input bit iclr, input logic [5:0] cn, input bit w, input bit a);
    @(negedge CLK);
    ICLR = iclr; CAT_N = cn; WATCH = w; ACK = a;
    @(posedge CLK);
    model_step(iclr, cn, w, a);
    #1;
    chk("gnt", int'(GNT), (m_ch >= 0) ? 1 : 0);
    chk("ibt", int'(IBT), (m_ch >= 0) ? m_ch + 2 : 0);
    chk("done", int'(DONE), int'(m_done));
    chk("tout", int'(TOUT), int'(m_tout));
    chk("errcnt", int'(ERRCNT), m_errcnt);
  endtask

  int seq[$];
  int rise_cyc[$];
  int gcnt, tcnt, dcnt, e0;
  bit prev_gnt;

  initial begin
    m_ch = -1; m_age = 0; m_last = 5; m_errcnt = 0; m_err = 0;

    // reset, then single request on channel 0
    step(1, 6'h3f, 0, 0);
    step(1, 6'h3f, 0, 0);
    step(0, 6'b111110, 1, 0);
    chk("first_ibt", int'(IBT), 2);
    for (int i = 0; i < 2; i++) step(0, 6'b111110, 1, 0);
    step(0, 6'b111111, 1, 1);
    chk("first_done", int'(DONE), 1);
    chk("first_gnt_off", int'(GNT), 0);

    // all channels requesting, ACK on each first grant cycle
    step(1, 6'h3f, 0, 0);
    prev_gnt = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step(0, 6'h00, 1, m_ch >= 0);
      if (GNT && !prev_gnt) begin
        seq.push_back(int'(IBT));
        rise_cyc.push_back(cyc);
      end
      prev_gnt = GNT;
    end
    chk("rr_count", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) begin
      chk("rr_ibt", seq[i], (i % 6) + 2);
      if (i > 0) chk("rr_gap", rise_cyc[i] - rise_cyc[i-1], 2);
    end

    // watchdog on channel 4, then channel 5 wins the next grant
    step(1, 6'h3f, 0, 0);
    step(0, 6'b101111, 1, 0);
    chk("wd_ibt", int'(IBT), 6);
    gcnt = 1;
    tcnt = 0;
    for (int i = 0; i < 200 && tcnt == 0; i++) begin
      step(0, 6'b001110, 1, 0);
      if (GNT) gcnt++;
      if (TOUT) tcnt++;
    end
    chk("wd_len", gcnt, 100);
    chk("wd_tout", tcnt, 1);
    chk("wd_errcnt", int'(ERRCNT), 1);
    step(0, 6'b001110, 1, 0);
    step(0, 6'b001110, 1, 0);
    chk("wd_next_ibt", int'(IBT), 7);

    // ACK exactly on the expiry cycle
    e0 = m_errcnt;
    dcnt = 0; tcnt = 0;
    for (int i = 0; i < 120; i++) begin
      step(0, 6'b000000, 1, (m_ch >= 0) && (m_age == WD - 1));
      if (DONE) dcnt++;
      if (TOUT) tcnt++;
      if (dcnt > 0) break;
    end
    chk("race_done", dcnt, 1);
    chk("race_tout", tcnt, 0);
    chk("race_errcnt", int'(ERRCNT), e0);

    // many timeouts saturate the error counter
    for (int i = 0; i < 17 * (WD + 3); i++) step(0, 6'h00, 1, 0);
    chk("sat_errcnt", int'(ERRCNT), 15);

    // reset mid-grant with ACK asserted, next grant restarts at channel 0
    while (m_ch < 0) step(0, 6'h00, 1, 0);
    step(0, 6'h00, 1, 0);
    step(1, 6'h00, 1, 1);
    chk("clr_gnt", int'(GNT), 0);
    chk("clr_err", int'(ERRCNT), 0);
    step(0, 6'h00, 1, 0);
    chk("clr_next_ibt", int'(IBT), 2);

    // WATCH low blocks grants; dropping WATCH mid-grant does not
    step(1, 6'h3f, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 6'h00, 0, 0);
    step(0, 6'b111011, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 6'h3f, 0, 0);
    chk("hold_gnt", int'(GNT), 1);
    chk("hold_ibt", int'(IBT), 4);
    step(0, 6'h3f, 0, 1);
    chk("hold_done", int'(DONE), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), 6'($urandom), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
